// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared constants, FSM state encoding and address packing for the LBP fetch path
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;
    localparam int PIX_W  = 8;
    localparam int NPIX   = 9;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        SLIDE,
        FILL,
        EMIT,
        DONE
    } state_t;

    // Power-of-two image: the linear address is simply the row above the column.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/lbp_win_shift.sv
// rtl/lbp_win_shift.sv - 3x3 pixel window register array with left shift and indexed load
module lbp_win_shift
    import lbp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift,
    input  logic                  load_en,
    input  logic [3:0]            load_idx,
    input  logic [PIX_W-1:0]      load_data,
    output logic [NPIX*PIX_W-1:0] win_data
);

    logic [PIX_W-1:0] pix_q [NPIX];
    logic [PIX_W-1:0] pix_d [NPIX];

    // Shift moves columns 1,2 into 0,1; the load then lands on top, so a shift
    // and a load of the right column in the same cycle compose correctly.
    always_comb begin
        for (int k = 0; k < NPIX; k++) begin
            pix_d[k] = pix_q[k];
        end
        if (shift) begin
            pix_d[0] = pix_q[1];
            pix_d[1] = pix_q[2];
            pix_d[3] = pix_q[4];
            pix_d[4] = pix_q[5];
            pix_d[6] = pix_q[7];
            pix_d[7] = pix_q[8];
        end
        for (int k = 0; k < NPIX; k++) begin
            if (load_en && (load_idx == 4'(k))) begin
                pix_d[k] = load_data;
            end
        end
    end

    // Window storage, cleared on reset so win_data reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NPIX; k++) begin
                pix_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NPIX; k++) begin
                pix_q[k] <= pix_d[k];
            end
        end
    end

    for (genvar g = 0; g < NPIX; g++) begin : g_out
        assign win_data[PIX_W*g +: PIX_W] = pix_q[g];
    end

endmodule

// File: rtl/lbp_fetch_sched.sv
// rtl/lbp_fetch_sched.sv - raster read scheduler and 3x3 window sequencer for the LBP pipeline
module lbp_fetch_sched
    import lbp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gray_ready,
    output logic                  gray_req,
    output logic [ADDR_W-1:0]     gray_addr,
    input  logic [PIX_W-1:0]      gray_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [NPIX*PIX_W-1:0] win_data,
    output logic [ADDR_W-1:0]     win_addr,
    output logic                  busy,
    output logic                  finish
);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [ROW_W-1:0]  y_q, y_d;
    logic [COL_W-1:0]  x_q, x_d;
    logic              cap_q, cap_d;
    logic [3:0]        cap_pos_q, cap_pos_d;
    logic              cap_shift_q, cap_shift_d;
    logic [ADDR_W-1:0] win_addr_q, win_addr_d;
    logic              win_valid_q, win_valid_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;

    logic              rd_en;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [3:0]        rd_pos;
    logic              rd_shift;
    logic [1:0]        prime_r, prime_c;

    // Column-major prime order: index i reads row offset i%3 of column offset i/3.
    always_comb begin
        prime_r = 2'd0;
        prime_c = 2'd0;
        case (idx_q)
            4'd1:    prime_r = 2'd1;
            4'd2:    prime_r = 2'd2;
            4'd3:    prime_c = 2'd1;
            4'd4:    begin prime_r = 2'd1; prime_c = 2'd1; end
            4'd5:    begin prime_r = 2'd2; prime_c = 2'd1; end
            4'd6:    prime_c = 2'd2;
            4'd7:    begin prime_r = 2'd1; prime_c = 2'd2; end
            4'd8:    begin prime_r = 2'd2; prime_c = 2'd2; end
            default: ;
        endcase
    end

    // Next-state, read issue and window-counter logic; a read only goes out when memory is ready.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        y_d        = y_q;
        x_d        = x_q;
        win_addr_d = win_addr_q;
        rd_en      = 1'b0;
        rd_row     = '0;
        rd_col     = '0;
        rd_pos     = 4'd0;
        rd_shift   = 1'b0;
        case (state_q)
            IDLE: begin
                y_d   = ROW_W'(1);
                x_d   = COL_W'(1);
                idx_d = 4'd0;
                if (gray_ready) state_d = PRIME;
            end
            PRIME: begin
                if (gray_ready) begin
                    rd_en  = 1'b1;
                    rd_row = y_q - ROW_W'(1) + ROW_W'(prime_r);
                    rd_col = x_q - COL_W'(1) + COL_W'(prime_c);
                    rd_pos = {2'b00, prime_r} * 4'd3 + {2'b00, prime_c};
                    if (idx_q == 4'd8) begin
                        idx_d   = 4'd0;
                        state_d = FILL;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            SLIDE: begin
                if (gray_ready) begin
                    rd_en    = 1'b1;
                    rd_row   = y_q - ROW_W'(1) + ROW_W'(idx_q);
                    rd_col   = x_q + COL_W'(1);
                    rd_pos   = idx_q * 4'd3 + 4'd2;
                    rd_shift = (idx_q == 4'd0);
                    if (idx_q == 4'd2) begin
                        idx_d   = 4'd0;
                        state_d = FILL;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            FILL: begin
                win_addr_d = pack_addr(y_q, x_q);
                state_d    = EMIT;
            end
            EMIT: begin
                if (win_ready) begin
                    if (x_q < COL_W'(IMG_W - 2)) begin
                        x_d     = x_q + COL_W'(1);
                        state_d = SLIDE;
                    end else if (y_q < ROW_W'(IMG_H - 2)) begin
                        x_d     = COL_W'(1);
                        y_d     = y_q + ROW_W'(1);
                        state_d = PRIME;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    // Capture bookkeeping and registered status outputs follow the next state.
    always_comb begin
        cap_d       = rd_en;
        cap_pos_d   = rd_pos;
        cap_shift_d = rd_shift;
        win_valid_d = (state_d == EMIT);
        busy_d      = (state_d == PRIME) || (state_d == SLIDE) ||
                      (state_d == FILL)  || (state_d == EMIT);
        finish_d    = (state_d == DONE);
    end

    // FSM and sequencing registers; reset drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            y_q         <= ROW_W'(1);
            x_q         <= COL_W'(1);
            cap_q       <= 1'b0;
            cap_pos_q   <= 4'd0;
            cap_shift_q <= 1'b0;
            win_addr_q  <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            y_q         <= y_d;
            x_q         <= x_d;
            cap_q       <= cap_d;
            cap_pos_q   <= cap_pos_d;
            cap_shift_q <= cap_shift_d;
            win_addr_q  <= win_addr_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
        end
    end

    lbp_win_shift u_win (
        .clk       (clk),
        .reset     (reset),
        .shift     (cap_q & cap_shift_q),
        .load_en   (cap_q),
        .load_idx  (cap_pos_q),
        .load_data (gray_data),
        .win_data  (win_data)
    );

    assign gray_req  = rd_en;
    assign gray_addr = rd_en ? pack_addr(rd_row, rd_col) : '0;
    assign win_valid = win_valid_q;
    assign win_addr  = win_addr_q;
    assign busy      = busy_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_fetch_sched.sv
// tb/tb_lbp_fetch_sched.sv - directed self-checking bench for lbp_fetch_sched
module tb_lbp_fetch_sched;

    logic        clk;
    logic        reset;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic [13:0] win_addr;
    logic        busy;
    logic        finish;

    logic [7:0]  mem [0:16383];
    int          vectors;
    int          miscompares;

    lbp_fetch_sched dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_addr   (win_addr),
        .busy       (busy),
        .finish     (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray memory with fixed one-cycle read latency.
    always_ff @(posedge clk) gray_data <= mem[gray_addr];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int wy, input int wx);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = mem[(wy - 1 + k / 3) * 128 + (wx - 1 + k % 3)];
        end
        return w;
    endfunction

    function automatic int exp_read(input int wy, input int wx, input int ri);
        if (wx == 1) return (wy - 1 + ri % 3) * 128 + (wx - 1 + ri / 3);
        return (wy - 1 + ri) * 128 + (wx + 1);
    endfunction

    task automatic next_read(input string tag, input int exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (gray_req === 1'b1) seen = 1'b1;
        end
        chk({tag, "_wait"}, 72'(seen), 72'd1);
        if (seen) chk(tag, 72'(gray_addr), 72'(exp));
    endtask

    task automatic wait_win(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (win_valid === 1'b1) seen = 1'b1;
        end
        chk({tag, "_wait"}, 72'(seen), 72'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},    72'(gray_req),  72'd0);
        chk({tag, "_gaddr"},  72'(gray_addr), 72'd0);
        chk({tag, "_valid"},  72'(win_valid), 72'd0);
        chk({tag, "_wdata"},  win_data,       72'd0);
        chk({tag, "_waddr"},  72'(win_addr),  72'd0);
        chk({tag, "_busy"},   72'(busy),      72'd0);
        chk({tag, "_finish"}, 72'(finish),    72'd0);
    endtask

    initial begin
        logic [71:0] held_data;
        logic [13:0] held_addr;
        int hy, hx, ry, rx, ri, hs, reads, last_addr;
        int prime_seq [9];

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom_range(0, 255));
        prime_seq = '{0, 128, 256, 1, 129, 257, 2, 130, 258};

        reset      = 1'b1;
        gray_ready = 1'b0;
        win_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        reset = 1'b0;

        // Idle with memory unavailable: nothing moves.
        repeat (2) @(negedge clk);
        chk("idle_req",  72'(gray_req), 72'd0);
        chk("idle_busy", 72'(busy),     72'd0);

        gray_ready = 1'b1;
        win_ready  = 1'b1;
        for (int i = 0; i < 4; i++) next_read($sformatf("prime_rd%0d", i), prime_seq[i]);
        // Memory unavailable for three cycles in the middle of the prime.
        @(posedge clk); #1;
        gray_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_req%0d", i), 72'(gray_req), 72'd0);
        end
        @(posedge clk); #1;
        gray_ready = 1'b1;
        for (int i = 4; i < 9; i++) next_read($sformatf("prime_rd%0d", i), prime_seq[i]);

        wait_win("win1");
        chk("win1_addr", 72'(win_addr),      72'd129);
        chk("win1_p4",   72'(win_data[39:32]), 72'(mem[129]));
        chk("win1_data", win_data,           exp_win(1, 1));
        chk("win1_busy", 72'(busy),          72'd1);

        next_read("slide_rd0", 3);
        next_read("slide_rd1", 131);
        next_read("slide_rd2", 259);
        win_ready = 1'b0;

        // Second window held under backpressure.
        wait_win("win2");
        chk("win2_addr", 72'(win_addr),        72'd130);
        chk("win2_p0",   72'(win_data[7:0]),   72'(mem[1]));
        chk("win2_p8",   72'(win_data[71:64]), 72'(mem[259]));
        chk("win2_data", win_data,             exp_win(1, 2));
        held_data = win_data;
        held_addr = win_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), 72'(win_valid), 72'd1);
            chk($sformatf("bp_data%0d", i),  win_data,       held_data);
            chk($sformatf("bp_addr%0d", i),  72'(win_addr),  72'(held_addr));
            chk($sformatf("bp_req%0d", i),   72'(gray_req),  72'd0);
        end
        win_ready = 1'b1;

        // Remainder of the frame against the raster model.
        hy = 1; hx = 3; ry = 1; rx = 3; ri = 0;
        hs = 2; reads = 12; last_addr = 0;
        for (int cyc = 0; cyc < 90000 && hs < 15876; cyc++) begin
            @(negedge clk);
            if (gray_req === 1'b1) begin
                chk("frame_rd", 72'(gray_addr), 72'(exp_read(ry, rx, ri)));
                reads++;
                ri++;
                if (ri == ((rx == 1) ? 9 : 3)) begin
                    ri = 0;
                    rx++;
                    if (rx == 127) begin rx = 1; ry++; end
                end
            end
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                chk("frame_waddr", 72'(win_addr), 72'(hy * 128 + hx));
                chk("frame_wdata", win_data,      exp_win(hy, hx));
                last_addr = int'(win_addr);
                hs++;
                hx++;
                if (hx == 127) begin hx = 1; hy++; end
            end
        end
        chk("handshakes", 72'(hs),        72'd15876);
        chk("last_addr",  72'(last_addr), 72'd16254);
        chk("reads",      72'(reads),     72'd48384);
        @(negedge clk);
        chk("done_finish", 72'(finish), 72'd1);
        chk("done_busy",   72'(busy),   72'd0);
        repeat (4) @(negedge clk);
        chk("sticky_finish", 72'(finish),    72'd1);
        chk("sticky_req",    72'(gray_req),  72'd0);
        chk("sticky_valid",  72'(win_valid), 72'd0);

        // Reset out of DONE, start a frame, then reset it mid-slide.
        reset = 1'b1;
        #1;
        chk_reset_outs("rst2");
        @(negedge clk);
        reset = 1'b0;
        next_read("re_rd0", 0);
        next_read("re_rd1", 128);
        wait_win("re_win1");
        chk("re_win1_addr", 72'(win_addr), 72'd129);
        next_read("re_slide0", 3);
        reset = 1'b1;
        #1;
        chk_reset_outs("rst3");
        @(negedge clk);
        reset = 1'b0;
        next_read("rs_rd0", 0);
        next_read("rs_rd1", 128);
        next_read("rs_rd2", 256);
        wait_win("rs_win1");
        chk("rs_win1_addr", 72'(win_addr), 72'd129);
        chk("rs_win1_data", win_data,      exp_win(1, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
